// File: rtl/ft245_pkg.sv
// Shared types and default strobe timing for the FT245-style parallel FIFO controller.
package ft245_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RD_STROBE  = 3'd1,
    ST_RD_RECOVER = 3'd2,
    ST_WR_SETUP   = 3'd3,
    ST_WR_STROBE  = 3'd4,
    ST_WR_RECOVER = 3'd5
  } state_t;

  typedef enum logic {
    GRANT_RX = 1'b0,
    GRANT_TX = 1'b1
  } grant_t;

  localparam int DEF_RD_PULSE   = 4;
  localparam int DEF_RD_RECOVER = 4;
  localparam int DEF_WR_SETUP   = 1;
  localparam int DEF_WR_PULSE   = 3;
  localparam int DEF_WR_RECOVER = 4;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ft245_strobe_timer.sv
// Load/count-down timer shared by every timed state; o_done is high once the count reaches zero.
module ft245_strobe_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_done
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/ft245_fifo_ctrl.sv
// FT245 FIFO sequencer: arbitrates RX/TX on the shared 8-bit bus and generates rd/wr/data_oe.
module ft245_fifo_ctrl
  import ft245_pkg::*;
#(
  parameter int RD_PULSE   = DEF_RD_PULSE,
  parameter int RD_RECOVER = DEF_RD_RECOVER,
  parameter int WR_SETUP   = DEF_WR_SETUP,
  parameter int WR_PULSE   = DEF_WR_PULSE,
  parameter int WR_RECOVER = DEF_WR_RECOVER
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rxf_n,
  input  logic        txe_n,
  input  logic [7:0]  bus_rdata,
  output logic [7:0]  bus_wdata,
  output logic        data_oe,
  output logic        rd,
  output logic        wr,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic [7:0]  rx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic [7:0]  tx_data,
  output logic [15:0] rx_count,
  output logic [15:0] tx_count
);

  localparam int MAX_P = max_of(max_of(max_of(RD_PULSE, RD_RECOVER),
                                       max_of(WR_SETUP, WR_PULSE)), WR_RECOVER);
  localparam int TW    = $clog2(MAX_P + 1);

  state_t        r_state;
  grant_t        r_last_grant;
  logic [7:0]    r_bus_wdata;
  logic          r_data_oe;
  logic          r_rd;
  logic          r_wr;
  logic          r_rx_valid;
  logic [7:0]    r_rx_data;
  logic [15:0]   r_rx_count;
  logic [15:0]   r_tx_count;

  logic          w_idle;
  logic          w_rx_ok;
  logic          w_tx_ok;
  logic          w_grant_rx;
  logic          w_grant_tx;
  logic          w_tmr_done;
  logic          w_tmr_load;
  logic [TW-1:0] w_tmr_val;
  logic          w_rd_done;
  logic          w_wr_done;

  // Flags are only looked at in IDLE; RX wins ties unless it was served last.
  assign w_idle     = (r_state == ST_IDLE);
  assign w_rx_ok    = !rxf_n && !r_rx_valid;
  assign w_tx_ok    = !txe_n && tx_valid;
  assign w_grant_rx = w_idle && w_rx_ok && (!w_tx_ok || (r_last_grant == GRANT_TX));
  assign w_grant_tx = w_idle && w_tx_ok && !w_grant_rx;
  assign w_rd_done  = (r_state == ST_RD_STROBE) && w_tmr_done;
  assign w_wr_done  = (r_state == ST_WR_STROBE) && w_tmr_done;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_val  = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_grant_rx) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = TW'(RD_PULSE - 1);
        end else if (w_grant_tx) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = TW'(WR_SETUP - 1);
        end
      end
      ST_RD_STROBE: begin
        w_tmr_load = w_tmr_done;
        w_tmr_val  = TW'(RD_RECOVER - 1);
      end
      ST_WR_SETUP: begin
        w_tmr_load = w_tmr_done;
        w_tmr_val  = TW'(WR_PULSE - 1);
      end
      ST_WR_STROBE: begin
        w_tmr_load = w_tmr_done;
        w_tmr_val  = TW'(WR_RECOVER - 1);
      end
      default: ;
    endcase
  end

  ft245_strobe_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_done     (w_tmr_done)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_last_grant <= GRANT_TX;
      r_bus_wdata  <= '0;
      r_data_oe    <= 1'b0;
      r_rd         <= 1'b0;
      r_wr         <= 1'b0;
      r_rx_valid   <= 1'b0;
      r_rx_data    <= '0;
      r_rx_count   <= '0;
      r_tx_count   <= '0;
    end else begin
      r_rx_count <= r_rx_count + 16'(w_rd_done);
      r_tx_count <= r_tx_count + 16'(w_wr_done);
      if (r_rx_valid && rx_ready) r_rx_valid <= 1'b0;

      unique case (r_state)
        ST_IDLE: begin
          if (w_grant_rx) begin
            r_rd         <= 1'b1;
            r_last_grant <= GRANT_RX;
            r_state      <= ST_RD_STROBE;
          end else if (w_grant_tx) begin
            r_bus_wdata  <= tx_data;
            r_data_oe    <= 1'b1;
            r_last_grant <= GRANT_TX;
            r_state      <= ST_WR_SETUP;
          end
        end
        ST_RD_STROBE: begin
          if (w_tmr_done) begin
            r_rd       <= 1'b0;
            r_rx_data  <= bus_rdata;
            r_rx_valid <= 1'b1;
            r_state    <= ST_RD_RECOVER;
          end
        end
        ST_RD_RECOVER: begin
          if (w_tmr_done) r_state <= ST_IDLE;
        end
        ST_WR_SETUP: begin
          if (w_tmr_done) begin
            r_wr    <= 1'b1;
            r_state <= ST_WR_STROBE;
          end
        end
        ST_WR_STROBE: begin
          if (w_tmr_done) begin
            r_wr    <= 1'b0;
            r_state <= ST_WR_RECOVER;
          end
        end
        ST_WR_RECOVER: begin
          // Bus stays driven for the first recovery cycle to give the FIFO hold time.
          r_data_oe <= 1'b0;
          if (w_tmr_done) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus_wdata = r_bus_wdata;
  assign data_oe   = r_data_oe;
  assign rd        = r_rd;
  assign wr        = r_wr;
  assign rx_valid  = r_rx_valid;
  assign rx_data   = r_rx_data;
  assign tx_ready  = w_grant_tx;
  assign rx_count  = r_rx_count;
  assign tx_count  = r_tx_count;

endmodule
